// File: rtl/xm_controller.sv
// Multi-cycle control unit for the X-Makina datapath: sequences fetch, decode, execute,
// memory and write-back, and holds in a sticky fault state on illegal opcodes or bad accesses.
module xm_controller #(
  parameter int unsigned WORD = 16
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [WORD-1:0] ir_i,
  input  logic            memRdy_i,
  input  logic            badMem_i,
  output logic            pcWr_o,
  output logic            regWr_o,
  output logic            memEn_o,
  output logic            memWr_o,
  output logic            irWr_o,
  output logic            byteOp_o,
  output logic            pcSel_o,
  output logic [1:0]      aluBSel_o,
  output logic [1:0]      regWrMode_o,
  output logic [2:0]      regWrSel_o,
  output logic [2:0]      regWrAdr_o,
  output logic [2:0]      regAdrA_o,
  output logic [2:0]      regAdrB_o,
  output logic [3:0]      aluOp_o,
  output logic [WORD-1:0] branchOffs_o,
  output logic            memWe_o,
  output logic            instDone_o,
  output logic            fault_o
);

  typedef enum logic [2:0] {
    StFetch, StFwait, StDecode, StExec, StMwait, StWb, StFault
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cls;

  assign cls          = ir_i[15:13];
  assign byteOp_o     = ir_i[6];
  assign aluOp_o      = ir_i[11:8];
  assign regAdrA_o    = ir_i[5:3];
  assign regAdrB_o    = ir_i[5:3];
  assign regWrMode_o  = ((cls == 3'b010) || (cls == 3'b100)) ? {1'b0, ir_i[6]} : 2'd0;
  // 13-bit word offset scaled to bytes and sign-extended to the datapath width
  assign branchOffs_o = {{(WORD-14){ir_i[12]}}, ir_i[12:0], 1'b0};

  always_ff @(posedge clk_i) begin
    if (arst_i) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcWr_o     = 1'b0;
    regWr_o    = 1'b0;
    memEn_o    = 1'b0;
    memWr_o    = 1'b0;
    irWr_o     = 1'b0;
    pcSel_o    = 1'b0;
    memWe_o    = 1'b0;
    instDone_o = 1'b0;
    fault_o    = 1'b0;
    aluBSel_o  = 2'd0;
    regWrSel_o = 3'd0;
    regWrAdr_o = ir_i[2:0];
    if (arst_i) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (badMem_i) begin
            state_d = StFault;
          end else begin
            memEn_o = 1'b1;
            state_d = StFwait;
          end
        end
        StFwait: begin
          if (badMem_i) begin
            state_d = StFault;
          end else if (memRdy_i) begin
            memWr_o = 1'b1;
            irWr_o  = 1'b1;
            pcWr_o  = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          unique case (cls)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: state_d = StExec;
            default:                                state_d = StFault;
          endcase
        end
        StExec: begin
          unique case (cls)
            3'b000: begin
              pcWr_o     = 1'b1;
              pcSel_o    = 1'b1;
              instDone_o = 1'b1;
              state_d    = StFetch;
            end
            3'b001: begin
              // Link register R5 captures the PC in the same cycle the branch is taken
              regWr_o    = 1'b1;
              regWrSel_o = 3'd1;
              regWrAdr_o = 3'd5;
              pcWr_o     = 1'b1;
              pcSel_o    = 1'b1;
              instDone_o = 1'b1;
              state_d    = StFetch;
            end
            3'b010: begin
              aluBSel_o  = {1'b0, ir_i[7]};
              regWr_o    = 1'b1;
              instDone_o = 1'b1;
              state_d    = StFetch;
            end
            3'b100, 3'b101: begin
              memEn_o   = 1'b1;
              aluBSel_o = 2'd2;
              memWe_o   = (cls == 3'b101);
              state_d   = badMem_i ? StFault : StMwait;
            end
            default: state_d = StFault;
          endcase
        end
        StMwait: begin
          if (badMem_i) begin
            state_d = StFault;
          end else if (memRdy_i) begin
            if (cls == 3'b100) begin
              memWr_o = 1'b1;
              state_d = StWb;
            end else begin
              instDone_o = 1'b1;
              state_d    = StFetch;
            end
          end
        end
        StWb: begin
          regWr_o    = 1'b1;
          regWrSel_o = 3'd2;
          instDone_o = 1'b1;
          state_d    = StFetch;
        end
        StFault: fault_o = 1'b1;
        default: state_d = StFault;
      endcase
    end
  end

endmodule

// File: tb/tb_xm_controller.sv
// Self-checking bench for xm_controller: directed vector table, corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_xm_controller;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic [15:0] ir_i = 16'h0;
  logic        memRdy_i = 1'b0;
  logic        badMem_i = 1'b0;
  logic        pcWr_o, regWr_o, memEn_o, memWr_o, irWr_o, byteOp_o, pcSel_o;
  logic [1:0]  aluBSel_o, regWrMode_o;
  logic [2:0]  regWrSel_o, regWrAdr_o, regAdrA_o, regAdrB_o;
  logic [3:0]  aluOp_o;
  logic [15:0] branchOffs_o;
  logic        memWe_o, instDone_o, fault_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xm_controller #(.WORD(16)) dut (
    .clk_i(clk), .arst_i(arst_i), .ir_i(ir_i), .memRdy_i(memRdy_i), .badMem_i(badMem_i),
    .pcWr_o(pcWr_o), .regWr_o(regWr_o), .memEn_o(memEn_o), .memWr_o(memWr_o),
    .irWr_o(irWr_o), .byteOp_o(byteOp_o), .pcSel_o(pcSel_o), .aluBSel_o(aluBSel_o),
    .regWrMode_o(regWrMode_o), .regWrSel_o(regWrSel_o), .regWrAdr_o(regWrAdr_o),
    .regAdrA_o(regAdrA_o), .regAdrB_o(regAdrB_o), .aluOp_o(aluOp_o),
    .branchOffs_o(branchOffs_o), .memWe_o(memWe_o), .instDone_o(instDone_o),
    .fault_o(fault_o)
  );

  // {pcWr, regWr, memEn, memWr, irWr, pcSel, memWe, instDone, fault}
  function automatic logic [8:0] strb();
    return {pcWr_o, regWr_o, memEn_o, memWr_o, irWr_o, pcSel_o, memWe_o, instDone_o, fault_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; outputs are then sampled 1 ns later, well before the next edge.
  task automatic step(input logic a, input logic [15:0] ir, input logic r, input logic b);
    @(negedge clk);
    arst_i = a; ir_i = ir; memRdy_i = r; badMem_i = b;
    #1;
  endtask

  typedef struct {
    string       name;
    logic        arst;
    logic [15:0] ir;
    logic        rdy;
    logic        bad;
    logic [8:0]  strb;
    logic [1:0]  bsel;
    logic [2:0]  wsel;
    logic [2:0]  wadr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic a, input logic [15:0] ir, input logic r,
                     input logic b, input logic [8:0] s, input logic [1:0] bs,
                     input logic [2:0] ws, input logic [2:0] wa);
    vec_t v;
    v.name = n; v.arst = a; v.ir = ir; v.rdy = r; v.bad = b;
    v.strb = s; v.bsel = bs; v.wsel = ws; v.wadr = wa;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int PF = 0, PFW = 1, PD = 2, PX = 3, PMW = 4, PWB = 5, PFLT = 6;
  int m_ph = PF;

  function automatic bit legal(input logic [2:0] c);
    return c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [45:0] model_out(input int ph, input logic a, input logic [15:0] ir,
                                            input logic r, input logic b);
    logic [8:0] s = '0;
    logic [1:0] bsel = 2'd0;
    logic [2:0] wsel = 3'd0;
    logic [2:0] wadr = ir[2:0];
    logic [2:0] c = ir[15:13];
    logic [1:0] mode;
    logic [15:0] offs;
    int signed w;
    w    = int'($signed(ir[12:0]));
    offs = 16'(w * 2);
    mode = (c == 3'd2 || c == 3'd4) ? {1'b0, ir[6]} : 2'd0;
    if (!a) begin
      if (ph == PF && !b) s[6] = 1'b1;
      if (ph == PFW && !b && r) s = 9'b100110000;
      if (ph == PX && c == 3'd0) s = 9'b100001010;
      if (ph == PX && c == 3'd1) begin s = 9'b110001010; wsel = 3'd1; wadr = 3'd5; end
      if (ph == PX && c == 3'd2) begin s = 9'b010000010; bsel = {1'b0, ir[7]}; end
      if (ph == PX && (c == 3'd4 || c == 3'd5)) begin
        s = {2'b00, 1'b1, 3'b000, (c == 3'd5), 2'b00};
        bsel = 2'd2;
      end
      if (ph == PMW && !b && r) s = (c == 3'd4) ? 9'b000100000 : 9'b000000010;
      if (ph == PWB) begin s = 9'b010000010; wsel = 3'd2; end
      if (ph == PFLT) s = 9'b000000001;
    end
    return {s, ir[6], bsel, mode, wsel, wadr, ir[5:3], ir[5:3], ir[11:8], offs};
  endfunction

  function automatic int model_next(input int ph, input logic a, input logic [15:0] ir,
                                    input logic r, input logic b);
    logic [2:0] c = ir[15:13];
    if (a) return PF;
    case (ph)
      PF:  return b ? PFLT : PFW;
      PFW: return b ? PFLT : (r ? PD : PFW);
      PD:  return legal(c) ? PX : PFLT;
      PX:  if (c == 3'd4 || c == 3'd5) return b ? PFLT : PMW;
           else return legal(c) ? PF : PFLT;
      PMW: return b ? PFLT : (r ? ((c == 3'd4) ? PWB : PF) : PMW);
      PWB: return PF;
      default: return PFLT;
    endcase
  endfunction

  function automatic logic [45:0] dut_out();
    return {strb(), byteOp_o, aluBSel_o, regWrMode_o, regWrSel_o, regWrAdr_o, regAdrA_o,
            regAdrB_o, aluOp_o, branchOffs_o};
  endfunction

  function automatic logic [15:0] rand_ir();
    logic [2:0] c;
    logic [15:0] v;
    int k = $urandom_range(0, 9);
    v = 16'($urandom);
    case (k)
      0: c = 3'd0; 1: c = 3'd1; 2, 3: c = 3'd2; 4, 5: c = 3'd4; 6, 7: c = 3'd5;
      8: c = 3'd3; default: c = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
    endcase
    v[15:13] = c;
    return v;
  endfunction

  initial begin : main
    int done_at;
    logic [15:0] rir;
    logic ra, rr, rb;
    int flt_run;

    // ALU 0x40A2: src=4, dst=2, constant operand
    add("rst",      1, 16'h40A2, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd2);
    add("alu_f",    0, 16'h40A2, 1, 0, 9'b001000000, 2'd0, 3'd0, 3'd2);
    add("alu_fw",   0, 16'h40A2, 1, 0, 9'b100110000, 2'd0, 3'd0, 3'd2);
    add("alu_dec",  0, 16'h40A2, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd2);
    add("alu_ex",   0, 16'h40A2, 1, 0, 9'b010000010, 2'd1, 3'd0, 3'd2);
    add("br_f",     0, 16'h1FFF, 1, 0, 9'b001000000, 2'd0, 3'd0, 3'd7);
    add("br_fw0",   0, 16'h1FFF, 0, 0, 9'b000000000, 2'd0, 3'd0, 3'd7);
    add("br_fw1",   0, 16'h1FFF, 1, 0, 9'b100110000, 2'd0, 3'd0, 3'd7);
    add("br_dec",   0, 16'h1FFF, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd7);
    add("br_ex",    0, 16'h1FFF, 0, 0, 9'b100001010, 2'd0, 3'd0, 3'd7);
    add("bl_f",     0, 16'h2003, 1, 0, 9'b001000000, 2'd0, 3'd0, 3'd3);
    add("bl_fw",    0, 16'h2003, 1, 0, 9'b100110000, 2'd0, 3'd0, 3'd3);
    add("bl_dec",   0, 16'h2003, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd3);
    add("bl_ex",    0, 16'h2003, 1, 0, 9'b110001010, 2'd0, 3'd1, 3'd5);
    add("st_f",     0, 16'hA041, 1, 0, 9'b001000000, 2'd0, 3'd0, 3'd1);
    add("st_fw",    0, 16'hA041, 1, 0, 9'b100110000, 2'd0, 3'd0, 3'd1);
    add("st_dec",   0, 16'hA041, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd1);
    add("st_ex",    0, 16'hA041, 0, 0, 9'b001000100, 2'd2, 3'd0, 3'd1);
    add("st_mw",    0, 16'hA041, 1, 0, 9'b000000010, 2'd0, 3'd0, 3'd1);
    add("ill_f",    0, 16'hE000, 1, 0, 9'b001000000, 2'd0, 3'd0, 3'd0);
    add("ill_fw",   0, 16'hE000, 1, 0, 9'b100110000, 2'd0, 3'd0, 3'd0);
    add("ill_dec",  0, 16'hE000, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd0);
    add("ill_flt",  0, 16'hE000, 1, 0, 9'b000000001, 2'd0, 3'd0, 3'd0);
    add("flt_hold", 0, 16'h4000, 1, 0, 9'b000000001, 2'd0, 3'd0, 3'd0);
    add("flt_rst",  1, 16'h4000, 1, 0, 9'b000000000, 2'd0, 3'd0, 3'd0);
    add("post_rst", 0, 16'h4000, 0, 0, 9'b001000000, 2'd0, 3'd0, 3'd0);

    foreach (tbl[i]) begin
      step(tbl[i].arst, tbl[i].ir, tbl[i].rdy, tbl[i].bad);
      check({tbl[i].name, "_strb"}, 64'(strb()), 64'(tbl[i].strb));
      check({tbl[i].name, "_sel"}, 64'({aluBSel_o, regWrSel_o, regWrAdr_o}),
            64'({tbl[i].bsel, tbl[i].wsel, tbl[i].wadr}));
    end

    // Branch offset sign extension and byte scaling
    step(1, 16'h1FFF, 0, 0); check("offs_neg1", 64'(branchOffs_o), 64'hFFFE);
    step(1, 16'h0001, 0, 0); check("offs_pos1", 64'(branchOffs_o), 64'h0002);
    step(1, 16'h1000, 0, 0); check("offs_min",  64'(branchOffs_o), 64'hE000);
    step(1, 16'hF0FF, 0, 0); check("offs_mix",  64'(branchOffs_o), 64'hE1FE);
    step(1, 16'h8840, 0, 0);
    check("ld_fields", 64'({byteOp_o, regWrMode_o, aluOp_o, regAdrA_o, regAdrB_o}),
          64'({1'b1, 2'd1, 4'h8, 3'd0, 3'd0}));

    // LD with three not-ready cycles in MWAIT: retires in cycle 9
    done_at = 0;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      step(0, 16'h8004, !(c >= 5 && c <= 7), 0);
      if (c == 8) check("ld_capture", 64'({memWr_o, irWr_o, regWr_o}), 64'b100);
      if (c == 9) check("ld_wb", 64'({regWr_o, regWrSel_o, regWrAdr_o}), 64'({1'b1, 3'd2, 3'd4}));
      if (instDone_o) done_at = c;
    end
    check("ld_latency", 64'(done_at), 64'd9);

    // badMem during FWAIT wins over ready: no capture, then FAULT
    step(1, 16'h4000, 1, 0);
    step(0, 16'h4000, 1, 0);
    step(0, 16'h4000, 1, 1); check("badfw_nostrb", 64'(strb()), 64'd0);
    step(0, 16'h4000, 1, 0); check("badfw_fault", 64'(strb()), 64'b000000001);

    // Illegal class holds FAULT for 10 cycles whatever the memory inputs do
    step(1, 16'hE000, 1, 0);
    step(0, 16'hE000, 1, 0);
    step(0, 16'hE000, 1, 0);
    step(0, 16'hE000, 1, 0);
    for (int c = 0; c < 10; c++) begin
      step(0, 16'h4000, c[0], c[1]);
      check("flt_sticky", 64'(strb()), 64'b000000001);
    end

    // Reset in the middle of FWAIT abandons the fetch and restarts
    step(1, 16'h4000, 0, 0);
    step(0, 16'h4000, 0, 0);
    step(0, 16'h4000, 0, 0);
    step(1, 16'h4000, 1, 0); check("rstfw_nostrb", 64'(strb()), 64'd0);
    step(0, 16'h4000, 1, 0); check("rstfw_fetch", 64'(strb()), 64'b001000000);

    // Randomized run against the model; ir changes only after it has been captured
    step(1, 16'h0, 0, 0);
    m_ph = PF;
    rir = rand_ir();
    flt_run = 0;
    for (int n = 0; n < 4000; n++) begin
      ra = ($urandom_range(0, 59) == 0) || (flt_run > 4);
      rr = ($urandom_range(0, 9) < 7);
      rb = ($urandom_range(0, 59) == 0);
      step(ra, rir, rr, rb);
      check("rand", 64'(dut_out()), 64'(model_out(m_ph, ra, rir, rr, rb)));
      if (!ra && m_ph == PFW && rr && !rb) rir = rand_ir();
      m_ph = model_next(m_ph, ra, ir_i, rr, rb);
      flt_run = (m_ph == PFLT) ? flt_run + 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
